// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and helpers for the multiplier issue/collect controller
// Purpose: request opcode enum, opcode-to-sign mapping, high-half select,
//          and the credit counter width for the default FIFO depth.
// Ports: none (package).
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_e;

  localparam int unsigned DEF_DEPTH = 8;
  // Credit counts 0..DEPTH inclusive, hence DEPTH+1 states.
  localparam int unsigned CREDIT_W  = $clog2(DEF_DEPTH + 1);

  // Returns {op1_sign, op2_sign}. MUL only keeps the low half, which does
  // not depend on operand signedness, so it uses the unsigned form.
  function automatic logic [1:0] op_signs(mul_op_e op);
    case (op)
      MULH:    return 2'b11;
      MULHSU:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Every opcode except MUL returns the upper half of the product.
  function automatic logic op_hi_sel(mul_op_e op);
    return (op != MUL);
  endfunction

endpackage

// File: rtl/mul_issue_collect_if.sv
// rtl/mul_issue_collect_if.sv - request/response handshake bundle for the issue/collect controller
// Purpose: groups the valid/ready request channel and the response channel.
// Signals: req_valid/req_ready/req_op/req_a/req_b/req_tag (request),
//          rsp_valid/rsp_ready/rsp_data/rsp_tag (response).
// Modports: master = requester/consumer side, slave = controller side.
interface mul_issue_collect_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
);
  import mul_pkg::*;

  logic             req_valid;
  logic             req_ready;
  mul_op_e          req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag
  );

endinterface

// File: rtl/mul_result_fifo.sv
// rtl/mul_result_fifo.sv - result buffer between the multiplier and the consumer
// Purpose: synchronous FIFO, DEPTH x DW, head shown combinationally, no
//          write-to-read bypass. When empty the last popped word is held.
// Ports: clk, rst (async active-high), clr (sync clear), wr_en/wr_data,
//        rd_en/rd_data (head), count (occupancy 0..DEPTH).
module mul_result_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 68
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [DW-1:0]          wr_data,
  input  logic                   rd_en,
  output logic [DW-1:0]          rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [DW-1:0] r_last;
  logic          w_empty;
  logic          w_pop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_pop   = rd_en & ~w_empty;
  assign count   = r_wr_ptr - r_rd_ptr;
  assign rd_data = w_empty ? r_last : r_mem[r_rd_ptr[AW-1:0]];

  // Overflow is impossible: the upstream credit scheme bounds occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_last   <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mul_issue_collect.sv
// rtl/mul_issue_collect.sv - issue/collect controller around a fixed-latency pipelined multiplier
// Purpose: accepts requests, drives multiplier operands and signs, tracks
//          tag/half-select alongside the multiplier, buffers results.
// Ports: clk, rst (async active-high), bus (slave: req_*/rsp_*), flush,
//        mul_op1/mul_op1_sign/mul_op2/mul_op2_sign (to multiplier),
//        mul_result (2*WIDTH product from multiplier).
module mul_issue_collect
  import mul_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int MUL_LATENCY = 6,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int TAG_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mul_issue_collect_if.slave   bus,
  input  logic                 flush,
  output logic [WIDTH-1:0]     mul_op1,
  output logic                 mul_op1_sign,
  output logic [WIDTH-1:0]     mul_op2,
  output logic                 mul_op2_sign,
  input  logic [2*WIDTH-1:0]   mul_result
);

  localparam int CW = $clog2(DEPTH + 1);

  logic                              w_accept;
  logic                              w_pop;
  logic [1:0]                        w_signs;
  logic [CW-1:0]                     r_credit;
  logic [CW-1:0]                     w_credit_nxt;
  logic                              r_req_ready;
  logic [MUL_LATENCY-1:0]            r_vld;
  logic [MUL_LATENCY-1:0]            r_hi;
  logic [MUL_LATENCY-1:0][TAG_W-1:0] r_tag;
  logic [WIDTH-1:0]                  w_half;
  logic [$clog2(DEPTH):0]            w_fifo_count;

  // A request presented during flush must not be taken.
  assign bus.req_ready = r_req_ready & ~flush;
  assign w_accept      = bus.req_valid & bus.req_ready;
  assign bus.rsp_valid = (w_fifo_count != '0);
  assign w_pop         = bus.rsp_valid & bus.rsp_ready;

  // Operands are gated so the multiplier only sees live requests.
  assign w_signs      = op_signs(bus.req_op);
  assign mul_op1      = w_accept ? bus.req_a : '0;
  assign mul_op2      = w_accept ? bus.req_b : '0;
  assign mul_op1_sign = w_accept & w_signs[1];
  assign mul_op2_sign = w_accept & w_signs[0];

  // Credit covers both in-flight products and buffered results, so a
  // result leaving the multiplier always has a FIFO slot waiting for it.
  always_comb begin
    w_credit_nxt = r_credit;
    if (w_accept && !w_pop)      w_credit_nxt = r_credit + CW'(1);
    else if (!w_accept && w_pop) w_credit_nxt = r_credit - CW'(1);
  end

  // req_ready is registered from the next credit value, so a pop while
  // full only reopens the request channel on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credit    <= '0;
      r_req_ready <= 1'b0;
    end else if (flush) begin
      r_credit    <= '0;
      r_req_ready <= 1'b1;
    end else begin
      r_credit    <= w_credit_nxt;
      r_req_ready <= (w_credit_nxt < CW'(DEPTH));
    end
  end

  // Tracking pipeline: the last stage lines up with mul_result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_hi  <= '0;
      r_tag <= '0;
    end else begin
      r_vld[0] <= w_accept;
      r_hi[0]  <= op_hi_sel(bus.req_op);
      r_tag[0] <= bus.req_tag;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_hi[i]  <= r_hi[i-1];
        r_tag[i] <= r_tag[i-1];
      end
      if (flush) r_vld <= '0;
    end
  end

  assign w_half = r_hi[MUL_LATENCY-1] ? mul_result[2*WIDTH-1:WIDTH]
                                      : mul_result[WIDTH-1:0];

  mul_result_fifo #(
    .DEPTH (DEPTH),
    .DW    (WIDTH + TAG_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .wr_en   (r_vld[MUL_LATENCY-1]),
    .wr_data ({r_tag[MUL_LATENCY-1], w_half}),
    .rd_en   (w_pop),
    .rd_data ({bus.rsp_tag, bus.rsp_data}),
    .count   (w_fifo_count)
  );

endmodule

// File: tb/tb_mul_issue_collect.sv
// tb/tb_mul_issue_collect.sv - self-checking bench for mul_issue_collect
module tb_mul_issue_collect;
  import mul_pkg::*;

  localparam int W  = 64;
  localparam int L  = 6;
  localparam int D  = 8;
  localparam int TW = 4;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [W-1:0]  mul_op1, mul_op2;
  logic          mul_op1_sign, mul_op2_sign;
  logic [2*W-1:0] mul_result;

  int n_checks = 0;
  int n_pass   = 0;
  int pops     = 0;
  int cyc      = 0;
  int first_pop = -1;
  int last_pop  = 0;
  logic [W-1:0] last_data;
  bit bp_rand = 0;
  logic [W+TW-1:0] exp_q [$];
  logic [2*W-1:0] mpipe [L];

  mul_issue_collect_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  mul_issue_collect #(.WIDTH(W), .MUL_LATENCY(L), .DEPTH(D), .TAG_W(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .flush        (flush),
    .mul_op1      (mul_op1),
    .mul_op1_sign (mul_op1_sign),
    .mul_op2      (mul_op2),
    .mul_op2_sign (mul_op2_sign),
    .mul_result   (mul_result)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Fixed-latency multiplier with no valid/stall of its own.
  function automatic logic [2*W-1:0] mul_model(logic [W-1:0] a, logic sa, logic [W-1:0] b, logic sb);
    logic [2*W-1:0] ae, be;
    ae = sa ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    be = sb ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ae * be;
  endfunction

  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) mpipe[i] <= mpipe[i-1];
    mpipe[0] <= mul_model(mul_op1, mul_op1_sign, mul_op2, mul_op2_sign);
  end
  assign mul_result = mpipe[L-1];

  // Reference result from the opcode semantics.
  function automatic logic [W-1:0] ref_result(mul_op_e op, logic [W-1:0] a, logic [W-1:0] b);
    logic [2*W-1:0] pu;
    logic signed [2*W-1:0] ps;
    pu = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      MUL:     return pu[W-1:0];
      MULHU:   return pu[2*W-1:W];
      MULH:    begin ps = 128'($signed(a)) * 128'($signed(b)); return ps[2*W-1:W]; end
      default: begin ps = 128'($signed(a)) * $signed({{W{1'b0}}, b}); return ps[2*W-1:W]; end
    endcase
  endfunction

  function automatic logic [1:0] ref_signs(mul_op_e op);
    if (op == MULH)   return 2'b11;
    if (op == MULHSU) return 2'b10;
    return 2'b00;
  endfunction

  // Scoreboard: expected results queued at accept, matched at every pop.
  always @(negedge clk) begin
    logic [W+TW-1:0] e;
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        chk("rsp_expected_present", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_tag", bus.rsp_tag, e[W+TW-1:W]);
          chk("rsp_data", bus.rsp_data, e[W-1:0]);
        end
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop  = cyc;
        last_data = bus.rsp_data;
      end
      if (flush) exp_q.delete();
      else if (bus.req_valid && bus.req_ready)
        exp_q.push_back({bus.req_tag, ref_result(bus.req_op, bus.req_a, bus.req_b)});
    end
  end

  task automatic issue(input mul_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag, output int waits);
    bit acc;
    acc = 0;
    waits = 0;
    bus.req_valid = 1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
    while (!acc && waits < 64) begin
      @(negedge clk);
      if (bus.req_ready) acc = 1;
      else begin
        waits++;
        @(posedge clk); #1;
        if (bp_rand) bus.rsp_ready = 1'($urandom_range(0, 1));
      end
    end
    chk("issue_accept", acc, 1'b1);
    if (acc) begin
      chk("op_signs", {mul_op1_sign, mul_op2_sign}, ref_signs(op));
      chk("mul_op1", mul_op1, a);
      chk("mul_op2", mul_op2, b);
    end
    @(posedge clk); #1;
    bus.req_valid = 0;
    if (bp_rand) bus.rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
      bus.rsp_ready = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    chk("drain_done", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int w, wsum, n, acc, nv;
    rst = 1; flush = 0;
    bus.req_valid = 1; bus.req_op = MULH; bus.req_a = 3; bus.req_b = 5; bus.req_tag = 0;
    bus.rsp_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, 64'd0);
    chk("rst_rsp_tag", bus.rsp_tag, 4'd0);
    chk("rst_mul_op1", mul_op1, 64'd0);
    chk("rst_signs", {mul_op1_sign, mul_op2_sign}, 2'b00);
    @(posedge clk); #1;
    rst = 0; bus.req_valid = 0;
    @(posedge clk); #1;

    // Single MUL and its latency.
    issue(MUL, 64'd3, 64'd5, 4'd2, w);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk); n++;
      if (bus.rsp_valid) break;
    end
    chk("accept_to_rsp_latency", n, 7);
    chk("mul_3x5_data", bus.rsp_data, 64'd15);
    chk("mul_3x5_tag", bus.rsp_tag, 4'd2);
    drain();

    // High-half variants with a = -1, b = 2.
    pops = 0;
    issue(MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'd1, w);
    issue(MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'd2, w);
    issue(MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'd3, w);
    drain();
    chk("hi_variants_pops", pops, 3);
    chk("mulhsu_last_data", last_data, 64'hFFFF_FFFF_FFFF_FFFF);

    // 20 back-to-back random requests at full throughput.
    pops = 0; first_pop = -1; wsum = 0;
    for (int i = 0; i < 20; i++) begin
      issue(mul_op_e'($urandom_range(0, 3)), rnd64(), rnd64(), 4'(i % 16), w);
      wsum += w;
    end
    chk("b2b_no_stall", wsum, 0);
    drain();
    chk("b2b_pops", pops, 20);
    chk("b2b_consecutive", last_pop - first_pop, 19);

    // Consumer stalled: credits cap accepts at DEPTH.
    bus.rsp_ready = 0; pops = 0; acc = 0;
    bus.req_valid = 1; bus.req_op = MUL; bus.req_a = rnd64(); bus.req_b = rnd64(); bus.req_tag = 0;
    for (int k = 0; k < 20 && acc < 10; k++) begin
      @(negedge clk);
      if (bus.req_ready) acc++;
      @(posedge clk); #1;
      if (bus.req_ready || acc > 0) begin
        bus.req_op = mul_op_e'($urandom_range(0, 3));
        bus.req_a = rnd64(); bus.req_b = rnd64(); bus.req_tag = 4'(acc);
      end
    end
    bus.req_valid = 0;
    chk("full_accepts", acc, D);
    @(negedge clk);
    chk("full_req_ready", bus.req_ready, 1'b0);
    chk("full_rsp_valid", bus.rsp_valid, 1'b1);
    @(posedge clk); #1;
    bus.rsp_ready = 1;
    @(negedge clk);
    chk("ready_same_cycle_as_pop", bus.req_ready, 1'b0);
    @(negedge clk);
    chk("ready_cycle_after_pop", bus.req_ready, 1'b1);
    drain();
    chk("full_pops", pops, D);

    // Flush with requests in flight.
    pops = 0;
    for (int i = 0; i < 4; i++) issue(MULHU, rnd64(), rnd64(), 4'(i + 4), w);
    @(posedge clk); #1;
    flush = 1; bus.req_valid = 1; bus.req_a = 1; bus.req_b = 1; bus.req_op = MUL;
    @(negedge clk);
    chk("flush_req_ready", bus.req_ready, 1'b0);
    @(posedge clk); #1;
    flush = 0; bus.req_valid = 0;
    chk("flush_credit", dut.r_credit, 4'd0);
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid) nv++;
    end
    chk("flush_no_rsp", nv, 0);
    @(posedge clk); #1;
    issue(MULH, rnd64(), rnd64(), 4'd9, w);
    drain();
    chk("post_flush_pops", pops, 1);

    // Reset in the middle of a burst.
    for (int i = 0; i < 5; i++) issue(mul_op_e'($urandom_range(0, 3)), rnd64(), rnd64(), 4'(i), w);
    bus.req_valid = 1; bus.req_a = 64'd11; bus.req_b = 64'd13; bus.req_op = MULH;
    rst = 1;
    #1;
    chk("midrst_req_ready", bus.req_ready, 1'b0);
    chk("midrst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("midrst_rsp_data", bus.rsp_data, 64'd0);
    chk("midrst_rsp_tag", bus.rsp_tag, 4'd0);
    chk("midrst_mul_op1", mul_op1, 64'd0);
    chk("midrst_signs", {mul_op1_sign, mul_op2_sign}, 2'b00);
    @(posedge clk); #1;
    rst = 0; bus.req_valid = 0;
    @(posedge clk); #1;
    pops = 0;
    issue(MUL, 64'd7, 64'd6, 4'd5, w);
    drain();
    chk("post_rst_pops", pops, 1);
    chk("post_rst_data", last_data, 64'd42);

    // Random traffic under random backpressure.
    bp_rand = 1;
    for (int i = 0; i < 30; i++) issue(mul_op_e'($urandom_range(0, 3)), rnd64(), rnd64(), 4'($urandom_range(0, 15)), w);
    drain();
    bp_rand = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
